pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage RV32 pipeline (F/D/E/M/W).
//  Derives per-stage stall/flush and Execute-stage operand forwarding from Decode/Execute/Mem/WB
//  register tags. Holds the pipeline during multi-cycle mul/div and data-memory waits.
//  Sits beside decode/execute and drives their pipeline-register enables/clears.
// PARAMETERS
//  REG_FILE_ADDRESS_WIDTH  5   register tag width
//  MDIV_TIMEOUT            64  max cycles in MDIV_WAIT before forced release
//  CNT_WIDTH               32  stall-cycle counter width
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  Rs1D,Rs2D      in   5   Decode source tags
//  Rs1E,Rs2E,RdE  in   5   Execute source/dest tags
//  ResultSrcE     in   2   Execute result select; 2'b01 = load
//  PCSrcE         in   1   taken branch/jump resolved in Execute
//  MulDivStartE   in   1   long-latency mul/div op present in Execute
//  MulDivDoneE    in   1   mul/div result valid this cycle
//  RdM            in   5   Memory dest tag
//  RegWriteM      in   1   Memory writes RF
//  MemAccessM     in   1   load/store in Memory
//  DmemReadyM     in   1   data memory ready
//  ImemReadyF     in   1   instruction memory ready
//  RdW            in   5   Writeback dest tag
//  RegWriteW      in   1   Writeback writes RF
//  StallF,StallD,StallE,StallM  out 1  hold stage register
//  FlushD,FlushE,FlushM,FlushW  out 1  clear stage register to bubble
//  ForwardAE,ForwardBE          out 2  00 RF, 01 ResultW, 10 ALUResultM
//  MdTimeout      out  1   sticky: mul/div watchdog fired
//  StallCycles    out  CNT_WIDTH  cycles with StallF=1, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RUN, timer=0, MdTimeout=0, StallCycles=0; while low all Stall*=0,
//   all Flush*=1, Forward*=00.
//  Forwarding (comb): ForwardAE=10 if RegWriteM&&RdM!=0&&RdM==Rs1E; else 01 if RegWriteW&&RdW!=0&&
//   RdW==Rs1E; else 00. Same for ForwardBE with Rs2E. M beats W. x0 never forwarded.
//  Conditions (comb): dmemWait=MemAccessM&&!DmemReadyM; mdBusy=(MulDivStartE||state==MDIV_WAIT)&&
//   !MulDivDoneE&&!timeoutNow; lwStall=ResultSrcE==01&&RdE!=0&&(RdE==Rs1D||RdE==Rs2D); imemWait=!ImemReadyF.
//  Priority, highest first (one applies per cycle):
//   dmemWait : StallF/D/E/M=1, FlushW=1.
//   mdBusy   : StallF/D/E=1, FlushM=1.
//   PCSrcE   : FlushD=1, FlushE=1; no stall (overrides lwStall/imemWait same cycle).
//   lwStall  : StallF=1, StallD=1, FlushE=1 (exactly one bubble).
//   imemWait : StallF=1, FlushD=1.
//  A flush is never asserted on a stalled stage; a PCSrcE masked by dmemWait/mdBusy takes effect
//   on the first unmasked cycle (PCSrcE is held since E is stalled).
//  FSM (state: RUN, MDIV_WAIT, DMEM_WAIT):
//   RUN->DMEM_WAIT on dmemWait; RUN->MDIV_WAIT on MulDivStartE&&!MulDivDoneE&&!dmemWait.
//   DMEM_WAIT->RUN when DmemReadyM; then MDIV_WAIT if mul/div still pending.
//   MDIV_WAIT->RUN on MulDivDoneE (release is same-cycle, comb on Done).
//   timer counts cycles in MDIV_WAIT, clears elsewhere; timeoutNow=timer==MDIV_TIMEOUT-1:
//   stalls release that cycle, MdTimeout<=1 (sticky until reset), next RUN.
//  Start+Done in same cycle: no stall, stays RUN. dmemWait during MDIV_WAIT: DMEM_WAIT, timer frozen.
//  StallCycles +1 per cycle with StallF=1, saturates at all-ones, no wrap.
//  Latency: all Stall/Flush/Forward are combinational from inputs+state, zero-cycle.
// STRUCTURE
//  pipeline_pkg: ctrl_state_e {RUN,MDIV_WAIT,DMEM_WAIT}; FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
//   RESULT_SRC_LOAD=2'b01.
//  One sub-module: forward_unit (comb, per-operand tag compare), instantiated twice (A, B).
//  FSM, timer, counter and priority encoder stay in pipeline_ctrl.
// TESTING
//  1 RegWriteM=1,RdM=3,Rs1E=3, RegWriteW=1,RdW=3 -> ForwardAE=10; RdM=0 -> ForwardAE=01; RdW=0 too -> 00.
//  2 ResultSrcE=01,RdE=5,Rs2D=5 -> one cycle StallF=StallD=FlushE=1; next cycle (RdE=0) all 0.
//  3 Same cycle as 2 with PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
//  4 MulDivStartE=1, Done after 10 cycles -> StallF/D/E=FlushM=1 for 10 cycles, 0 on Done cycle,
//    StallCycles=10.
//  5 MulDivStartE held, Done never -> release after MDIV_TIMEOUT cycles, MdTimeout=1 sticky.
//  6 MemAccessM=1,DmemReadyM=0 for 3 cycles with PCSrcE=1 -> Stall F-M=1,FlushW=1, FlushD/E=0;
//    ready -> FlushD=FlushE=1. rst_n pulse mid-wait -> RUN, counters 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and encodings for the RV32 5-stage pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MDIV_WAIT = 2'd1,
    DMEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// Execute-stage operand forwarding select for one source operand.
// Memory-stage results beat writeback results; x0 is never forwarded.
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int REG_FILE_ADDRESS_WIDTH = 5
) (
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] rs,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] rd_m,
  input  logic                              reg_write_m,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] rd_w,
  input  logic                              reg_write_w,
  output logic [1:0]                        fwd
);

  always_comb begin
    // NOTE: default assigned first so every path drives fwd and no latch is inferred.
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      fwd = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: per-stage stall/flush, operand forwarding,
// mul/div and data-memory wait sequencing with a mul/div watchdog.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_FILE_ADDRESS_WIDTH = 5,
  parameter int MDIV_TIMEOUT           = 64,
  parameter int CNT_WIDTH              = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE,
  input  logic [1:0]                        ResultSrcE,
  input  logic                              PCSrcE,
  input  logic                              MulDivStartE,
  input  logic                              MulDivDoneE,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
  input  logic                              RegWriteM,
  input  logic                              MemAccessM,
  input  logic                              DmemReadyM,
  input  logic                              ImemReadyF,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW,
  input  logic                              RegWriteW,
  output logic                              StallF,
  output logic                              StallD,
  output logic                              StallE,
  output logic                              StallM,
  output logic                              FlushD,
  output logic                              FlushE,
  output logic                              FlushM,
  output logic                              FlushW,
  output logic [1:0]                        ForwardAE,
  output logic [1:0]                        ForwardBE,
  output logic                              MdTimeout,
  output logic [CNT_WIDTH-1:0]              StallCycles
);

  localparam int TIMER_W = $clog2(MDIV_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MDIV_TIMEOUT - 1);

  ctrl_state_e        state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [1:0]         fwd_a, fwd_b;

  logic dmem_wait, md_pending, timeout_now, md_busy, lw_stall, imem_wait;

  forward_unit #(.REG_FILE_ADDRESS_WIDTH(REG_FILE_ADDRESS_WIDTH)) u_fwd_a (
    .rs(Rs1E), .rd_m(RdM), .reg_write_m(RegWriteM), .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(fwd_a)
  );

  forward_unit #(.REG_FILE_ADDRESS_WIDTH(REG_FILE_ADDRESS_WIDTH)) u_fwd_b (
    .rs(Rs2E), .rd_m(RdM), .reg_write_m(RegWriteM), .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(fwd_b)
  );

  assign ForwardAE = rst_n ? fwd_a : FWD_RF;
  assign ForwardBE = rst_n ? fwd_b : FWD_RF;

  assign dmem_wait   = MemAccessM && !DmemReadyM;
  assign md_pending  = MulDivStartE && !MulDivDoneE;
  assign timeout_now = (state == MDIV_WAIT) && (timer == TIMER_LAST);
  assign md_busy     = (MulDivStartE || (state == MDIV_WAIT)) && !MulDivDoneE && !timeout_now;
  assign lw_stall    = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign imem_wait   = !ImemReadyF;

  // Priority encoder: exactly one hazard class acts per cycle, so a flush
  // never lands on a stage that is being held.
  always_comb begin
    {StallF, StallD, StallE, StallM} = '0;
    {FlushD, FlushE, FlushM, FlushW} = '0;
    if (!rst_n) begin
      {FlushD, FlushE, FlushM, FlushW} = '1;
    end else if (dmem_wait) begin
      {StallF, StallD, StallE, StallM} = '1;
      FlushW = 1'b1;
    end else if (md_busy) begin
      {StallF, StallD, StallE} = '1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (imem_wait) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (dmem_wait)       state_next = DMEM_WAIT;
        else if (md_pending) state_next = MDIV_WAIT;
      end
      MDIV_WAIT: begin
        if (dmem_wait)                       state_next = DMEM_WAIT;
        else if (MulDivDoneE || timeout_now) state_next = RUN;
      end
      DMEM_WAIT: begin
        if (!dmem_wait) state_next = md_pending ? MDIV_WAIT : RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // The watchdog timer survives a data-memory wait that interrupts a mul/div
  // so the total mul/div time stays bounded; it clears once back in RUN.
  always_comb begin
    timer_next = '0;
    unique case (state)
      MDIV_WAIT: begin
        if (state_next == MDIV_WAIT)      timer_next = timer + TIMER_W'(1);
        else if (state_next == DMEM_WAIT) timer_next = timer;
      end
      DMEM_WAIT: begin
        if (state_next != RUN) timer_next = timer;
      end
      default: timer_next = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      timer       <= '0;
      MdTimeout   <= 1'b0;
      StallCycles <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      if (timeout_now) MdTimeout <= 1'b1;
      if (StallF && (StallCycles != '1)) StallCycles <= StallCycles + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus
// randomized cycles compared against a behavioural reference model.
module tb_pipeline_ctrl;

  localparam int AW      = 5;
  localparam int MDIV_TO = 16;
  localparam int CW      = 8;
  localparam int CMAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE, MulDivStartE, MulDivDoneE, RegWriteM, MemAccessM;
  logic          DmemReadyM, ImemReadyF, RegWriteW;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          MdTimeout;
  logic [CW-1:0] StallCycles;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  bit m_md_wait, m_dmem_hold, m_to;
  int m_age, m_scnt;
  logic [3:0] exp_stall, exp_flush;
  logic [1:0] exp_fa, exp_fb;

  pipeline_ctrl #(.REG_FILE_ADDRESS_WIDTH(AW), .MDIV_TIMEOUT(MDIV_TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MulDivStartE(MulDivStartE), .MulDivDoneE(MulDivDoneE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemAccessM(MemAccessM), .DmemReadyM(DmemReadyM),
    .ImemReadyF(ImemReadyF), .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MdTimeout(MdTimeout), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit timeout_ref();
    return m_md_wait && (m_age == MDIV_TO - 1);
  endfunction

  task automatic model_reset();
    m_md_wait = 0; m_dmem_hold = 0; m_to = 0; m_age = 0; m_scnt = 0;
  endtask

  task automatic model_eval();
    bit dmem, busy, lw;
    exp_stall = '0; exp_flush = '0; exp_fa = 2'b00; exp_fb = 2'b00;
    if (!rst_n) begin
      exp_flush = 4'hF;
      return;
    end
    dmem = MemAccessM && !DmemReadyM;
    busy = (MulDivStartE || m_md_wait) && !MulDivDoneE && !timeout_ref();
    lw   = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (dmem)             begin exp_stall = 4'b1111; exp_flush = 4'b0001; end
    else if (busy)        begin exp_stall = 4'b1110; exp_flush = 4'b0010; end
    else if (PCSrcE)      begin exp_flush = 4'b1100; end
    else if (lw)          begin exp_stall = 4'b1100; exp_flush = 4'b0100; end
    else if (!ImemReadyF) begin exp_stall = 4'b1000; exp_flush = 4'b1000; end
    exp_fa = fwd_ref(Rs1E);
    exp_fb = fwd_ref(Rs2E);
  endtask

  task automatic model_update();
    bit dmem, pending, to_now;
    dmem    = MemAccessM && !DmemReadyM;
    pending = MulDivStartE && !MulDivDoneE;
    to_now  = timeout_ref();
    if (exp_stall[3] && m_scnt < CMAX) m_scnt++;
    if (to_now) m_to = 1;
    if (dmem) begin
      m_dmem_hold = 1;
      m_md_wait   = 0;
    end else if (m_dmem_hold) begin
      m_dmem_hold = 0;
      m_md_wait   = pending;
      if (!pending) m_age = 0;
    end else if (m_md_wait) begin
      if (MulDivDoneE || to_now) begin m_md_wait = 0; m_age = 0; end
      else m_age++;
    end else begin
      m_md_wait = pending;
      m_age = 0;
    end
  endtask

  task automatic compare_all();
    check("stall_FDEM", {28'd0, StallF, StallD, StallE, StallM}, {28'd0, exp_stall});
    check("flush_DEMW", {28'd0, FlushD, FlushE, FlushM, FlushW}, {28'd0, exp_flush});
    check("fwd_a", {30'd0, ForwardAE}, {30'd0, exp_fa});
    check("fwd_b", {30'd0, ForwardBE}, {30'd0, exp_fb});
    check("md_timeout", {31'd0, MdTimeout}, {31'd0, m_to});
    check("stall_cycles", {24'd0, StallCycles}, 32'(m_scnt));
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic run_cycle();
    #1;
    model_eval();
    compare_all();
    @(posedge clk);
    if (rst_n) model_update();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; PCSrcE = 0; MulDivStartE = 0; MulDivDoneE = 0;
    RegWriteM = 0; MemAccessM = 0; DmemReadyM = 1; ImemReadyF = 1; RegWriteW = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    run_cycle();
    rst_n = 1'b1;
  endtask

  task automatic randomize_inputs();
    Rs1D = AW'($urandom_range(7)); Rs2D = AW'($urandom_range(7));
    Rs1E = AW'($urandom_range(7)); Rs2E = AW'($urandom_range(7));
    RdE  = AW'($urandom_range(7)); RdM  = AW'($urandom_range(7)); RdW = AW'($urandom_range(7));
    ResultSrcE   = 2'($urandom_range(3));
    PCSrcE       = ($urandom_range(99) < 15);
    MulDivStartE = ($urandom_range(99) < 20);
    MulDivDoneE  = ($urandom_range(99) < 15);
    RegWriteM    = ($urandom_range(99) < 60);
    RegWriteW    = ($urandom_range(99) < 60);
    MemAccessM   = ($urandom_range(99) < 30);
    DmemReadyM   = ($urandom_range(99) < 50);
    ImemReadyF   = ($urandom_range(99) < 80);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check("reset_flush", {28'd0, FlushD, FlushE, FlushM, FlushW}, 32'hF);
    check("reset_stall", {28'd0, StallF, StallD, StallE, StallM}, 32'h0);
    run_cycle();
    rst_n = 1'b1;

    // Forwarding priority and x0 suppression
    RegWriteM = 1; RdM = 3; Rs1E = 3; RegWriteW = 1; RdW = 3;
    #1 check("fwd_m_beats_w", {30'd0, ForwardAE}, 32'h2);
    run_cycle();
    RdM = 0;
    #1 check("fwd_w_when_rdm_x0", {30'd0, ForwardAE}, 32'h1);
    run_cycle();
    RdW = 0;
    #1 check("fwd_rf_both_x0", {30'd0, ForwardAE}, 32'h0);
    run_cycle();
    idle();

    // Load-use: exactly one bubble
    ResultSrcE = 2'b01; RdE = 5; Rs2D = 5;
    #1 check("lw_stall", {29'd0, StallF, StallD, FlushE}, 32'h7);
    run_cycle();
    RdE = 0;
    #1 check("lw_released", {24'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}, 32'h0);
    run_cycle();

    // Taken branch overrides load-use
    RdE = 5; PCSrcE = 1;
    #1 check("branch_over_lw", {28'd0, FlushD, FlushE, StallF, StallD}, 32'hC);
    run_cycle();
    idle();

    // Mul/div with Done after 10 cycles
    apply_reset();
    MulDivStartE = 1;
    for (int i = 0; i < 10; i++) begin
      #1 check("md_busy", {30'd0, StallE, FlushM}, 32'h3);
      run_cycle();
    end
    MulDivDoneE = 1;
    #1 check("md_done_release", {29'd0, StallF, StallD, StallE}, 32'h0);
    run_cycle();
    idle();
    #1 check("md_stall_count", {24'd0, StallCycles}, 32'd10);
    run_cycle();

    // Start with Done in the same cycle: no stall
    MulDivStartE = 1; MulDivDoneE = 1;
    #1 check("md_start_done", {31'd0, StallF}, 32'h0);
    run_cycle();
    idle();
    #1 check("md_start_done_run", {31'd0, StallF}, 32'h0);
    run_cycle();

    // Mul/div watchdog
    apply_reset();
    MulDivStartE = 1;
    for (int i = 0; i < MDIV_TO; i++) run_cycle();
    #1 check("md_timeout_release", {31'd0, StallF}, 32'h0);
    run_cycle();
    idle();
    #1 check("md_timeout_set", {31'd0, MdTimeout}, 32'h1);
    for (int i = 0; i < 4; i++) run_cycle();
    #1 check("md_timeout_sticky", {31'd0, MdTimeout}, 32'h1);
    run_cycle();

    // Data-memory wait masks a taken branch until ready
    apply_reset();
    MemAccessM = 1; DmemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("dmem_wait", {26'd0, StallF, StallD, StallE, StallM, FlushW, FlushD}, 32'h3E);
      run_cycle();
    end
    DmemReadyM = 1;
    #1 check("dmem_ready_branch", {28'd0, FlushD, FlushE, StallF, StallE}, 32'hC);
    run_cycle();
    PCSrcE = 0; DmemReadyM = 0;
    run_cycle();
    run_cycle();
    rst_n = 1'b0;
    model_reset();
    #1 check("reset_mid_wait_cnt", {24'd0, StallCycles}, 32'd0);
    run_cycle();
    rst_n = 1'b1;
    idle();
    #1 check("after_reset_run", {28'd0, StallF, StallD, StallE, StallM}, 32'h0);
    run_cycle();

    // Mul/div interrupted by a data-memory wait, then resumed
    MulDivStartE = 1;
    run_cycle(); run_cycle();
    MemAccessM = 1; DmemReadyM = 0;
    run_cycle(); run_cycle();
    DmemReadyM = 1;
    for (int i = 0; i < MDIV_TO + 2; i++) run_cycle();
    idle();
    run_cycle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs();
      run_cycle();
    end

    // Stall counter saturation
    idle();
    apply_reset();
    ImemReadyF = 0;
    for (int i = 0; i < CMAX + 5; i++) run_cycle();
    #1 check("stall_cnt_saturate", {24'd0, StallCycles}, 32'(CMAX));
    run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
